// File: rtl/cache_sa_stat_engine.sv
// Set-associative cache tag/statistics engine.
// Holds tags, valid/dirty bits and replacement state only, with no data array.
// Each request runs IDLE -> LOOKUP -> UPDATE and produces a one-cycle response.
module cache_sa_stat_engine #(
  parameter int CACHE_SIZE  = 8192,
  parameter int LINE_SIZE   = 32,
  parameter int ASSOC       = 4,
  parameter int ADDR_W      = 31,
  parameter int REPL        = 0,
  parameter int WRITE_ALLOC = 1,
  parameter int CNT_W       = 31
) (
  input  logic                                          clk_41,
  input  logic                                          rst_41,
  input  logic                                          req_valid_41,
  output logic                                          req_ready_41,
  input  logic [ADDR_W-1:0]                             req_addr_41,
  input  logic                                          req_we_41,
  output logic                                          resp_valid_41,
  output logic                                          resp_hit_41,
  output logic [((ASSOC > 1) ? $clog2(ASSOC) : 1)-1:0]  resp_way_41,
  output logic                                          resp_evict_41,
  output logic [CNT_W-1:0]                              hits_41,
  output logic [CNT_W-1:0]                              misses_41,
  output logic [CNT_W-1:0]                              evictions_41,
  output logic [CNT_W-1:0]                              writebacks_41
);

  localparam int OB    = $clog2(LINE_SIZE);
  localparam int SETS  = CACHE_SIZE / (LINE_SIZE * ASSOC);
  localparam int IB    = $clog2(SETS);
  localparam int IDX_W = (IB > 0) ? IB : 1;
  localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int TAG_W = ADDR_W - OB - IB;

  // Reset ages: way k starts with age k, so way 0 is the first LRU victim.
  function automatic logic [ASSOC*WAY_W-1:0] age_init();
    logic [ASSOC*WAY_W-1:0] r;
    r = '0;
    for (int k = 0; k < ASSOC; k++) r[k*WAY_W +: WAY_W] = WAY_W'(k);
    return r;
  endfunction

  localparam logic [ASSOC*WAY_W-1:0] AGE_INIT = age_init();

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

  state_t                   state_reg, state_next;
  logic [ADDR_W-1:0]        addr_reg;
  logic                     we_reg;
  logic                     hit_reg;
  logic [WAY_W-1:0]         way_reg;
  logic                     vic_valid_reg;
  logic                     vic_dirty_reg;
  logic                     resp_valid_reg, resp_hit_reg, resp_evict_reg;
  logic [WAY_W-1:0]         resp_way_reg;
  logic [CNT_W-1:0]         hits_reg, misses_reg, evictions_reg, writebacks_reg;

  logic [TAG_W-1:0]         tag_mem [SETS][ASSOC];
  logic [ASSOC-1:0]         valid_reg [SETS];
  logic [ASSOC-1:0]         dirty_reg [SETS];
  logic [ASSOC*WAY_W-1:0]   age_reg [SETS];
  logic [WAY_W-1:0]         fifo_ptr_reg [SETS];

  logic [IDX_W-1:0]         set_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [ASSOC-1:0]         cur_valid, cur_dirty, match;
  logic [ASSOC*WAY_W-1:0]   cur_age;
  logic [WAY_W-1:0]         cur_ptr;
  logic                     lookup_hit, any_inv, accept, do_alloc, upd_en;
  logic [WAY_W-1:0]         hit_way, inv_way, lru_way, victim_way, target_way;
  logic [ASSOC-1:0]         valid_next, dirty_next;
  logic [ASSOC*WAY_W-1:0]   age_next;
  logic [WAY_W-1:0]         ptr_next;
  logic [WAY_W-1:0]         sel_age, cur_a;

  // With a fully associative cache there are no index bits and every access hits set 0.
  assign set_idx   = (IB == 0) ? '0 : IDX_W'(addr_reg >> OB);
  assign req_tag   = TAG_W'(addr_reg >> (OB + IB));
  assign cur_valid = valid_reg[set_idx];
  assign cur_dirty = dirty_reg[set_idx];
  assign cur_age   = age_reg[set_idx];
  assign cur_ptr   = fifo_ptr_reg[set_idx];
  assign accept    = (state_reg == IDLE) && req_valid_41;
  assign upd_en    = (state_reg == UPDATE);
  // A write miss without write-allocate leaves tag and replacement state untouched.
  assign do_alloc  = hit_reg || !we_reg || (WRITE_ALLOC != 0);

  for (genvar gi = 0; gi < ASSOC; gi++) begin : g_match
    assign match[gi] = cur_valid[gi] && (tag_mem[set_idx][gi] == req_tag);
  end

  // Hit way and victim selection; scanning downwards leaves the lowest index selected.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    any_inv = 1'b0;
    for (int k = ASSOC - 1; k >= 0; k--) begin
      if (match[k]) hit_way = WAY_W'(k);
      if (!cur_valid[k]) begin
        inv_way = WAY_W'(k);
        any_inv = 1'b1;
      end
      if (cur_age[k*WAY_W +: WAY_W] == '0) lru_way = WAY_W'(k);
    end
    lookup_hit = |match;
    if (any_inv)        victim_way = inv_way;
    else if (REPL == 1) victim_way = cur_ptr;
    else                victim_way = lru_way;
    target_way = lookup_hit ? hit_way : victim_way;
  end

  // Next set state computed from the registered lookup result.
  always_comb begin
    valid_next = cur_valid;
    dirty_next = cur_dirty;
    age_next   = cur_age;
    ptr_next   = cur_ptr;
    sel_age    = cur_age[way_reg*WAY_W +: WAY_W];
    cur_a      = '0;
    if (hit_reg) begin
      if (we_reg) dirty_next[way_reg] = 1'b1;
    end else if (do_alloc) begin
      valid_next[way_reg] = 1'b1;
      dirty_next[way_reg] = we_reg;
      if (REPL == 1 && ASSOC > 1 && way_reg == cur_ptr) ptr_next = cur_ptr + WAY_W'(1);
    end
    if (REPL == 0 && ASSOC > 1 && do_alloc) begin
      for (int k = 0; k < ASSOC; k++) begin
        cur_a = cur_age[k*WAY_W +: WAY_W];
        if (WAY_W'(k) == way_reg) age_next[k*WAY_W +: WAY_W] = WAY_W'(ASSOC - 1);
        else if (cur_a > sel_age) age_next[k*WAY_W +: WAY_W] = cur_a - WAY_W'(1);
      end
    end
  end

  // Per-set valid/dirty/replacement registers, written only for the addressed set.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    always_ff @(posedge clk_41 or negedge rst_41) begin
      if (!rst_41) begin
        valid_reg[gi]    <= '0;
        dirty_reg[gi]    <= '0;
        age_reg[gi]      <= AGE_INIT;
        fifo_ptr_reg[gi] <= '0;
      end else if (upd_en && set_idx == IDX_W'(gi)) begin
        valid_reg[gi]    <= valid_next;
        dirty_reg[gi]    <= dirty_next;
        age_reg[gi]      <= age_next;
        fifo_ptr_reg[gi] <= ptr_next;
      end
    end
  end

  // Tag store; contents are qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk_41) begin
    if (upd_en && !hit_reg && do_alloc) tag_mem[set_idx][way_reg] <= req_tag;
  end

  // FSM state register.
  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // FSM next-state and ready decode.
  always_comb begin
    state_next   = state_reg;
    req_ready_41 = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_41 = 1'b1;
        if (req_valid_41) state_next = LOOKUP;
      end
      LOOKUP:  state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, lookup result capture, registered response and counters.
  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) begin
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      hit_reg        <= 1'b0;
      way_reg        <= '0;
      vic_valid_reg  <= 1'b0;
      vic_dirty_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_way_reg   <= '0;
      resp_evict_reg <= 1'b0;
      hits_reg       <= '0;
      misses_reg     <= '0;
      evictions_reg  <= '0;
      writebacks_reg <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      if (accept) begin
        addr_reg <= req_addr_41;
        we_reg   <= req_we_41;
      end
      if (state_reg == LOOKUP) begin
        hit_reg       <= lookup_hit;
        way_reg       <= target_way;
        vic_valid_reg <= cur_valid[victim_way];
        vic_dirty_reg <= cur_dirty[victim_way];
      end
      if (upd_en) begin
        resp_valid_reg <= 1'b1;
        resp_hit_reg   <= hit_reg;
        resp_way_reg   <= do_alloc ? way_reg : '0;
        resp_evict_reg <= !hit_reg && do_alloc && vic_valid_reg;
        if (hit_reg) begin
          hits_reg <= sat_inc(hits_reg);
        end else begin
          misses_reg <= sat_inc(misses_reg);
          if (do_alloc && vic_valid_reg) evictions_reg <= sat_inc(evictions_reg);
          if (do_alloc && vic_valid_reg && vic_dirty_reg) writebacks_reg <= sat_inc(writebacks_reg);
        end
      end
    end
  end

  assign resp_valid_41 = resp_valid_reg;
  assign resp_hit_41   = resp_hit_reg;
  assign resp_way_41   = resp_way_reg;
  assign resp_evict_41 = resp_evict_reg;
  assign hits_41       = hits_reg;
  assign misses_41     = misses_reg;
  assign evictions_41  = evictions_reg;
  assign writebacks_41 = writebacks_reg;

endmodule

// File: tb/tb_cache_sa_stat_engine.sv
// Bench for cache_sa_stat_engine: three instances (LRU, FIFO, no-write-allocate)
// driven from a vector table, with a response scoreboard and corner-case sequences.
module tb_cache_sa_stat_engine;
  localparam int AW = 31;
  localparam int CW = 31;
  localparam int WW = 2;
  localparam int ND = 3;
  localparam int NV = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] req_valid;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic          rdy [ND];
  logic          rv  [ND];
  logic          rh  [ND];
  logic          re  [ND];
  logic [WW-1:0] rw  [ND];
  logic [CW-1:0] hits [ND];
  logic [CW-1:0] misses [ND];
  logic [CW-1:0] evs [ND];
  logic [CW-1:0] wbs [ND];

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int            d;
    logic [AW-1:0] addr;
    logic          we;
    logic          hit;
    logic [WW-1:0] way;
    logic          evict;
    int            h, m, e, w;
  } vec_t;

  typedef struct {
    int            d;
    logic          hit;
    logic [WW-1:0] way;
    logic          evict;
    int            acc;
    int            h, m, e, w;
  } exp_t;

  vec_t vt [NV];
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    cache_sa_stat_engine #(
      .REPL        ((gi == 1) ? 1 : 0),
      .WRITE_ALLOC ((gi == 2) ? 0 : 1)
    ) u_dut (
      .clk_41        (clk),
      .rst_41        (rst_n),
      .req_valid_41  (req_valid[gi]),
      .req_ready_41  (rdy[gi]),
      .req_addr_41   (req_addr),
      .req_we_41     (req_we),
      .resp_valid_41 (rv[gi]),
      .resp_hit_41   (rh[gi]),
      .resp_way_41   (rw[gi]),
      .resp_evict_41 (re[gi]),
      .hits_41       (hits[gi]),
      .misses_41     (misses[gi]),
      .evictions_41  (evs[gi]),
      .writebacks_41 (wbs[gi])
    );
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      if (rv[d] === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", 64'(d + 1), 64'd0);
        end else begin
          e = sbq.pop_front();
          $display("resp dut%0d hit=%0d way=%0d evict=%0d h=%0d m=%0d e=%0d wb=%0d", d, rh[d], rw[d], re[d],
                   hits[d], misses[d], evs[d], wbs[d]);
          check("resp_dut", 64'(d), 64'(e.d));
          check("latency", 64'(cyc - e.acc), 64'd2);
          check("hit", 64'(rh[d]), 64'(e.hit));
          check("way", 64'(rw[d]), 64'(e.way));
          check("evict", 64'(re[d]), 64'(e.evict));
          check("hits", 64'(hits[d]), 64'(e.h));
          check("misses", 64'(misses[d]), 64'(e.m));
          check("evictions", 64'(evs[d]), 64'(e.e));
          check("writebacks", 64'(wbs[d]), 64'(e.w));
        end
      end
    end
  end

  // Drive one request at a negedge while ready, push its expectation, wait for the response.
  task automatic drive(input vec_t v, input bit hold_busy);
    exp_t e;
    int n;
    @(negedge clk);
    n = 0;
    while (rdy[v.d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rdy[v.d] !== 1'b1) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      req_addr = v.addr;
      req_we   = v.we;
      req_valid[v.d] = 1'b1;
      e.d = v.d; e.hit = v.hit; e.way = v.way; e.evict = v.evict;
      e.acc = cyc + 1; e.h = v.h; e.m = v.m; e.e = v.e; e.w = v.w;
      sbq.push_back(e);
      @(negedge clk);
      if (hold_busy) begin
        // Valid stays high through LOOKUP and UPDATE; it must be ignored.
        check("busy_ready_lookup", 64'(rdy[v.d]), 64'd0);
        @(negedge clk);
        check("busy_ready_update", 64'(rdy[v.d]), 64'd0);
        @(negedge clk);
        check("ready_after_update", 64'(rdy[v.d]), 64'd1);
      end
      req_valid[v.d] = 1'b0;
      n = 0;
      while (sbq.size() != 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (sbq.size() != 0) begin
        check("resp_timeout", 64'd0, 64'd1);
        sbq.delete();
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      check({tag, "_resp_valid"}, 64'(rv[d]), 64'd0);
      check({tag, "_resp_hit"}, 64'(rh[d]), 64'd0);
      check({tag, "_resp_way"}, 64'(rw[d]), 64'd0);
      check({tag, "_resp_evict"}, 64'(re[d]), 64'd0);
      check({tag, "_hits"}, 64'(hits[d]), 64'd0);
      check({tag, "_misses"}, 64'(misses[d]), 64'd0);
      check({tag, "_evictions"}, 64'(evs[d]), 64'd0);
      check({tag, "_writebacks"}, 64'(wbs[d]), 64'd0);
    end
  endtask

  initial begin
    vec_t v;
    // dut0: LRU, write-allocate
    vt[0]  = '{0, 31'h0,    1'b0, 1'b0, 2'd0, 1'b0, 0, 1,  0, 0};
    vt[1]  = '{0, 31'h1C,   1'b0, 1'b1, 2'd0, 1'b0, 1, 1,  0, 0};
    vt[2]  = '{0, 31'h800,  1'b0, 1'b0, 2'd1, 1'b0, 1, 2,  0, 0};
    vt[3]  = '{0, 31'h1000, 1'b0, 1'b0, 2'd2, 1'b0, 1, 3,  0, 0};
    vt[4]  = '{0, 31'h1800, 1'b0, 1'b0, 2'd3, 1'b0, 1, 4,  0, 0};
    vt[5]  = '{0, 31'h0,    1'b0, 1'b1, 2'd0, 1'b0, 2, 4,  0, 0};
    vt[6]  = '{0, 31'h2000, 1'b0, 1'b0, 2'd1, 1'b1, 2, 5,  1, 0};
    vt[7]  = '{0, 31'h800,  1'b0, 1'b0, 2'd2, 1'b1, 2, 6,  2, 0};
    vt[8]  = '{0, 31'h20,   1'b1, 1'b0, 2'd0, 1'b0, 2, 7,  2, 0};
    vt[9]  = '{0, 31'h820,  1'b0, 1'b0, 2'd1, 1'b0, 2, 8,  2, 0};
    vt[10] = '{0, 31'h1020, 1'b0, 1'b0, 2'd2, 1'b0, 2, 9,  2, 0};
    vt[11] = '{0, 31'h1820, 1'b0, 1'b0, 2'd3, 1'b0, 2, 10, 2, 0};
    vt[12] = '{0, 31'h2020, 1'b0, 1'b0, 2'd0, 1'b1, 2, 11, 3, 1};
    // dut1: FIFO
    vt[13] = '{1, 31'h0,    1'b0, 1'b0, 2'd0, 1'b0, 0, 1,  0, 0};
    vt[14] = '{1, 31'h800,  1'b0, 1'b0, 2'd1, 1'b0, 0, 2,  0, 0};
    vt[15] = '{1, 31'h1000, 1'b0, 1'b0, 2'd2, 1'b0, 0, 3,  0, 0};
    vt[16] = '{1, 31'h1800, 1'b0, 1'b0, 2'd3, 1'b0, 0, 4,  0, 0};
    vt[17] = '{1, 31'h0,    1'b0, 1'b1, 2'd0, 1'b0, 1, 4,  0, 0};
    vt[18] = '{1, 31'h2000, 1'b0, 1'b0, 2'd0, 1'b1, 1, 5,  1, 0};
    vt[19] = '{1, 31'h0,    1'b0, 1'b0, 2'd1, 1'b1, 1, 6,  2, 0};
    // dut2: no write-allocate
    vt[20] = '{2, 31'h40,   1'b1, 1'b0, 2'd0, 1'b0, 0, 1,  0, 0};
    vt[21] = '{2, 31'h40,   1'b0, 1'b0, 2'd0, 1'b0, 0, 2,  0, 0};
    vt[22] = '{2, 31'h40,   1'b0, 1'b1, 2'd0, 1'b0, 1, 2,  0, 0};

    req_valid = '0;
    req_addr  = '0;
    req_we    = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("ready_after_reset", 64'(rdy[d]), 64'd1);

    for (int i = 0; i < NV; i++) begin
      $display("req dut%0d addr=%0h we=%0d", vt[i].d, vt[i].addr, vt[i].we);
      drive(vt[i], 1'b0);
    end

    // Valid held while busy: one accept, one response, ready low for two cycles.
    v = '{0, 31'h1800, 1'b0, 1'b1, 2'd3, 1'b0, 3, 11, 3, 1};
    $display("req dut0 addr=%0h we=0 (valid held while busy)", v.addr);
    drive(v, 1'b1);
    repeat (4) @(negedge clk);
    check("no_second_accept", 64'(sbq.size()), 64'd0);

    // Reset asserted while the request sits in LOOKUP: no response, everything cleared.
    @(negedge clk);
    req_addr = 31'h4000;
    req_we   = 1'b0;
    req_valid[0] = 1'b1;
    $display("req dut0 addr=4000 we=0 (reset during lookup)");
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_resp_in_reset", 64'(rv[0]), 64'd0);
    end
    check_reset_state("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", 64'(rdy[0]), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("no_late_resp", 64'(rv[0]), 64'd0);
    end
    v = '{0, 31'h4000, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1, 0, 0};
    $display("req dut0 addr=%0h we=0 (after reset)", v.addr);
    drive(v, 1'b0);
    v = '{0, 31'h1800, 1'b0, 1'b0, 2'd1, 1'b0, 0, 2, 0, 0};
    $display("req dut0 addr=%0h we=0 (after reset)", v.addr);
    drive(v, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_sa_stat_engine.md
Name: cache_sa_stat_engine

Overview:
- Parametrised set-associative cache tag/statistics engine for trace-driven cache studies.
- Consumes one address request at a time over a valid/ready handshake and returns a per-access hit/miss response.
- Supports selectable LRU or FIFO replacement, write-back dirty tracking with write-allocate or no-write-allocate, and saturating hit/miss/eviction/writeback counters.
- Tag state only; no data array is held.

Parameters:
- CACHE_SIZE, 8192: total capacity in bytes; power of two.
- LINE_SIZE, 32: line size in bytes; power of two, >= 4.
- ASSOC, 4: ways per set; power of two, 1..CACHE_SIZE/LINE_SIZE. Maximum value means fully associative (index width 0).
- ADDR_W, 31: request address width.
- REPL, 0: replacement policy; 0 = LRU, 1 = FIFO.
- WRITE_ALLOC, 1: 1 = write miss allocates; 0 = write miss bypasses.
- CNT_W, 31: width of each statistics counter.

Ports:
- clk_41  in  1  clock; all state changes on rising edge.
- rst_41  in  1  asynchronous, active-low reset.
- req_valid_41  in  1  request present.
- req_ready_41  out  1  engine can accept a request.
- req_addr_41  in  ADDR_W  byte address.
- req_we_41  in  1  1 = write, 0 = read.
- resp_valid_41  out  1  one-cycle pulse; response fields valid.
- resp_hit_41  out  1  1 = hit.
- resp_way_41  out  max(1,clog2(ASSOC))  way hit or allocated; 0 on bypass.
- resp_evict_41  out  1  a valid line was replaced.
- hits_41  out  CNT_W  hit count.
- misses_41  out  CNT_W  miss count.
- evictions_41  out  CNT_W  valid-line replacement count.
- writebacks_41  out  CNT_W  dirty-line eviction count.

Behaviour:
- Address split:
  - OB = clog2(LINE_SIZE).
  - SETS = CACHE_SIZE/(LINE_SIZE*ASSOC).
  - IB = clog2(SETS).
  - index = addr[OB+IB-1:OB].
  - tag = addr[ADDR_W-1:OB+IB].
- Reset (rst_41 low, asynchronous, any state):
  - FSM goes to IDLE.
  - All valid and dirty bits cleared.
  - LRU age of way k in every set = k.
  - FIFO pointer of every set = 0.
  - All counters 0; resp_valid_41 = 0; resp_hit_41 = 0; resp_way_41 = 0; resp_evict_41 = 0.
  - req_ready_41 = 1 once reset is released.
  - An in-flight request is dropped with no response.
- FSM states: IDLE -> LOOKUP -> UPDATE -> IDLE.
  - IDLE: req_ready_41 = 1. A request is accepted on a rising edge with req_valid_41 & req_ready_41. Address and write flag are latched; next state is LOOKUP.
  - LOOKUP: req_ready_41 = 0. Compare the latched tag against all valid ways of the set. Hit way is the lowest-index matching way.
    - On a miss, victim selection: lowest-index invalid way first; otherwise the way with age 0 (LRU) or the way at the FIFO pointer.
  - UPDATE: req_ready_41 = 0. Apply state changes; responses are registered so resp_valid_41 pulses high in the cycle after the UPDATE edge. Return to IDLE.
- Latency and throughput:
  - resp_valid_41 is high exactly 2 cycles after the accept edge.
  - Next accept is possible 3 cycles after the previous accept.
  - req_valid_41 while req_ready_41 = 0 is ignored.
- Hit:
  - hits +1.
  - A write sets the dirty bit.
  - LRU: ways with age greater than the hit way's age decrement; hit way age becomes ASSOC-1.
  - FIFO: no change.
- Read miss, or write miss with WRITE_ALLOC=1:
  - misses +1.
  - Victim gets tag, valid = 1, dirty = req_we.
  - If the victim was valid: evictions +1 and resp_evict_41 = 1. If the victim was also dirty: writebacks +1.
  - LRU: promote the victim as on a hit.
  - FIFO: pointer advances by 1 mod ASSOC, but only when the victim was the pointer way (invalid-fill otherwise leaves it).
- Write miss with WRITE_ALLOC=0:
  - misses +1.
  - No tag, valid, dirty or replacement change.
  - resp_way_41 = 0; resp_evict_41 = 0.
- Counters saturate at all-ones and do not wrap.
- ASSOC=1: replacement state unused; victim is always way 0.

Test Plan:
- Default parameters, reset released:
  - read 0x0 -> resp_valid_41 2 cycles after accept, hit=0, way=0, misses=1.
  - then read 0x1C -> hit=1, way=0, hits=1.
- LRU:
  - reads 0x0, 0x800, 0x1000, 0x1800 (set 0) -> 4 misses, ways 0..3, no evictions.
  - read 0x0 -> hit.
  - read 0x2000 -> miss, way=1, resp_evict_41=1, evictions=1.
  - read 0x800 -> miss.
- REPL=1, same sequence as the LRU case -> 0x2000 replaces way 0; the following read of 0x0 misses.
- Writeback:
  - write 0x0 (miss, dirty).
  - reads 0x800, 0x1000, 0x1800, 0x2000 -> last one evicts way 0, writebacks=1, evictions=1.
- WRITE_ALLOC=0: write 0x40 -> miss, way=0, evict=0; read 0x40 -> miss again, misses=2.
- Reset mid-operation:
  - drive rst_41 low during LOOKUP -> no resp_valid_41 pulse; all counters 0.
  - after release, req_ready_41=1; read of the prior address misses.
